// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data RAM between the CPU load/store unit (port 0)
//   and the UART loader (port 1). Round-robin arbitration with a req/ack
//   handshake. Byte and halfword loads are lane-selected and extended.
//   Sub-word stores use read-modify-write because the RAM has a single
//   whole-word write enable.
//
// Optional feature macro: DMEM_MISALIGN_CHK_EN
//   When defined, adds err0_o/err1_o. Misaligned half/word accesses then skip
//   the RAM and complete with ack+err. When undefined, the low address bits
//   that do not fit the access size are ignored.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   reqN_i / ackN_o         request (held until ack) / one-cycle completion
//   weN_i, addrN_i          store flag, byte address
//   wdataN_i, sizeN_i       right-aligned store data, 00 byte/01 half/1x word
//   unsN_i                  load zero-extend (1) or sign-extend (0)
//   rdataN_o                load result, held until the next load to that port
//   mem_addr_o/we_o/wdata_o RAM word address, write enable, write data
//   mem_rdata_i             RAM read data, one cycle after mem_addr_o
//   busy_o                  high whenever the FSM is not in IDLE
//   errN_o                  misalignment error (DMEM_MISALIGN_CHK_EN only)
module dmem_arbiter #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [31:0]       addr0_i,
  input  logic [31:0]       addr1_i,
  input  logic [31:0]       wdata0_i,
  input  logic [31:0]       wdata1_i,
  input  logic [1:0]        size0_i,
  input  logic [1:0]        size1_i,
  input  logic              uns0_i,
  input  logic              uns1_i,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic [31:0]       rdata0_o,
  output logic [31:0]       rdata1_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              busy_o
`ifdef DMEM_MISALIGN_CHK_EN
  ,
  output logic              err0_o,
  output logic              err1_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ACCESS   = 3'd1,
    S_WAIT     = 3'd2,
    S_MERGE_WR = 3'd3,
    S_RESP     = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                gnt_q, gnt_d;
  logic                we_q, we_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                ack0_q, ack0_d, ack1_q, ack1_d;
  logic [31:0]         rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                busy_q, busy_d;
  logic                mis_s;
`ifdef DMEM_MISALIGN_CHK_EN
  logic                err0_q, err0_d, err1_q, err1_d;
`endif

  // Address bits above the RAM are deliberately dropped (accesses wrap).
  logic addr_unused;
  assign addr_unused = ^{addr0_i[31:ADDR_W+2], addr1_i[31:ADDR_W+2]};

  // Little-endian lane select plus zero/sign extension for loads.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = {{24{b[7] & ~uns}}, b};
      2'b01:   r = {{16{h[15] & ~uns}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Insert right-aligned store data into the old word at the addressed lane.
  function automatic logic [31:0] merge_store(input logic [31:0] old_w,
                                              input logic [31:0] wd,
                                              input logic [1:0]  off,
                                              input logic [1:0]  size);
    logic [31:0] r;
    r = old_w;
    case (size)
      2'b00: begin
        case (off)
          2'd0:    r[7:0]   = wd[7:0];
          2'd1:    r[15:8]  = wd[7:0];
          2'd2:    r[23:16] = wd[7:0];
          default: r[31:24] = wd[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) r[31:16] = wd[15:0];
        else        r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic r;
    case (size)
      2'b00:   r = 1'b0;
      2'b01:   r = off[0];
      default: r = (off != 2'd0);
    endcase
    return r;
  endfunction

  // Next-state and next-output logic; all outputs are registered from *_d.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    uns_d       = uns_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mis_s       = 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
    err0_d      = 1'b0;
    err1_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0_i || req1_i) begin
          // On a tie the port that did not win last time goes next.
          gnt_d   = (req0_i && req1_i) ? ~last_q : req1_i;
          last_d  = gnt_d;
          we_d    = gnt_d ? we1_i    : we0_i;
          addr_d  = gnt_d ? addr1_i[ADDR_W+1:0] : addr0_i[ADDR_W+1:0];
          wdata_d = gnt_d ? wdata1_i : wdata0_i;
          size_d  = gnt_d ? size1_i  : size0_i;
          uns_d   = gnt_d ? uns1_i   : uns0_i;
`ifdef DMEM_MISALIGN_CHK_EN
          mis_s   = misaligned(size_d, addr_d[1:0]);
          err0_d  = mis_s & ~gnt_d;
          err1_d  = mis_s & gnt_d;
`endif
          if (mis_s) begin
            state_d = S_RESP;
          end else begin
            state_d    = S_ACCESS;
            mem_addr_d = addr_d[ADDR_W+1:2];
            // Whole-word stores write straight away; everything else reads first.
            mem_we_d   = we_d & size_d[1];
            if (we_d && size_d[1]) mem_wdata_d = wdata_d;
            else                   mem_wdata_d = mem_wdata_q;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (we_q && size_q[1]) state_d = S_RESP;
        else                   state_d = S_WAIT;
      end
      S_WAIT: begin
        if (we_q) begin
          mem_wdata_d = merge_store(mem_rdata_i, wdata_q, addr_q[1:0], size_q);
          mem_we_d    = 1'b1;
          state_d     = S_MERGE_WR;
        end else begin
          if (gnt_q) rdata1_d = load_extract(mem_rdata_i, addr_q[1:0], size_q, uns_q);
          else       rdata0_d = load_extract(mem_rdata_i, addr_q[1:0], size_q, uns_q);
          state_d = S_RESP;
        end
      end
      S_MERGE_WR: state_d = S_RESP;
      S_RESP:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    // RESP always lasts one cycle, so entering it is exactly the ack pulse.
    ack0_d = (state_d == S_RESP) & ~gnt_d;
    ack1_d = (state_d == S_RESP) & gnt_d;
    busy_d = (state_d != S_IDLE);
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 32'd0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= 32'd0;
      rdata1_q    <= 32'd0;
      busy_q      <= 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      busy_q      <= busy_d;
`ifdef DMEM_MISALIGN_CHK_EN
      err0_q      <= err0_d;
      err1_q      <= err1_d;
`endif
    end
  end

  assign ack0_o      = ack0_q;
  assign ack1_o      = ack1_q;
  assign rdata0_o    = rdata0_q;
  assign rdata1_o    = rdata1_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_we_o    = mem_we_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = busy_q;
`ifdef DMEM_MISALIGN_CHK_EN
  assign err0_o      = err0_q;
  assign err1_o      = err1_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic compared against a byte-lane arithmetic model of the RAM contents.
module tb_dmem_arbiter;
  localparam int ADDR_W = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_i, req1_i, we0_i, we1_i, uns0_i, uns1_i;
  logic [31:0] addr0_i, addr1_i, wdata0_i, wdata1_i;
  logic [1:0] size0_i, size1_i;
  logic ack0_o, ack1_o, mem_we_o, busy_o;
  logic [31:0] rdata0_o, rdata1_o, mem_wdata_o, mem_rdata_i;
  logic [ADDR_W-1:0] mem_addr_o;
`ifdef DMEM_MISALIGN_CHK_EN
  logic err0_o, err1_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_mem [0:63];   // model of the 64 words the bench uses
  logic [31:0] exp_rd  [0:1];    // expected held rdata per port
  logic [31:0] ram [0:(1<<ADDR_W)-1];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_i(req0_i), .req1_i(req1_i), .we0_i(we0_i), .we1_i(we1_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .size0_i(size0_i), .size1_i(size1_i), .uns0_i(uns0_i), .uns1_i(uns1_i),
    .ack0_o(ack0_o), .ack1_o(ack1_o), .rdata0_o(rdata0_o), .rdata1_o(rdata1_o),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
`ifdef DMEM_MISALIGN_CHK_EN
    , .err0_o(err0_o), .err1_o(err1_o)
`endif
  );

  // Synchronous single-port RAM seen by the arbiter.
  always @(posedge clk) begin
    if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
    mem_rdata_i <= ram[mem_addr_o];
  end

  function automatic logic [5:0] word_idx(input logic [31:0] addr);
    logic [31:0] t;
    t = (addr % 32'h0001_0000) / 32'd4;
    return t[5:0];
  endfunction

  function automatic logic is_mis(input logic [31:0] addr, input logic [1:0] size);
`ifdef DMEM_MISALIGN_CHK_EN
    int off;
    off = int'(addr % 32'd4);
    if (size == 2'd1) return (off % 2) != 0;
    if (size >= 2'd2) return off != 0;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int exp_latency(input logic we, input logic [1:0] size, input logic mis);
    if (mis) return 2;
    if (we && size >= 2'd2) return 3;
    if (!we) return 4;
    return 5;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size, input logic uns);
    int off;
    logic [31:0] w, v;
    off = int'(addr % 32'd4);
    w = ref_mem[word_idx(addr)];
    if (size == 2'd0) begin
      v = (w >> (8 * off)) & 32'h0000_00FF;
      if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (w >> (16 * (off / 2))) & 32'h0000_FFFF;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic void model_store(input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] size);
    int off, sh;
    logic [31:0] mask, w;
    off = int'(addr % 32'd4);
    w = ref_mem[word_idx(addr)];
    if (size >= 2'd2) begin
      w = wdata;
    end else begin
      sh   = (size == 2'd0) ? 8 * off : 16 * (off / 2);
      mask = ((size == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
      w    = (w & ~mask) | ((wdata << sh) & mask);
    end
    ref_mem[word_idx(addr)] = w;
  endfunction

  // Drives one transaction from an IDLE cycle and reports what was observed.
  task automatic run_txn(input int p, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                         output int lat, output int exp_lat, output int we_cnt,
                         output logic [ADDR_W-1:0] we_addr, output logic [31:0] rdata,
                         output logic [31:0] exp_rdata, output logic err,
                         output logic exp_err, output logic other_ack);
    logic mis;
    mis = is_mis(addr, size);
    exp_err = mis;
    exp_lat = exp_latency(we, size, mis);
    if (!we && !mis) exp_rd[p] = model_load(addr, size, uns);
    exp_rdata = exp_rd[p];
    if (p == 0) begin
      req0_i = 1'b1; we0_i = we; addr0_i = addr; wdata0_i = wdata; size0_i = size; uns0_i = uns;
    end else begin
      req1_i = 1'b1; we1_i = we; addr1_i = addr; wdata1_i = wdata; size1_i = size; uns1_i = uns;
    end
    lat = -1; we_cnt = 0; we_addr = '0; rdata = 32'd0; err = 1'b0; other_ack = 1'b0;
    for (int c = 2; c <= 20 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (mem_we_o) begin we_cnt++; we_addr = mem_addr_o; end
      if ((p == 0 && ack1_o) || (p == 1 && ack0_o)) other_ack = 1'b1;
      if ((p == 0 && ack0_o) || (p == 1 && ack1_o)) begin
        lat = c;
        rdata = (p == 0) ? rdata0_o : rdata1_o;
`ifdef DMEM_MISALIGN_CHK_EN
        err = (p == 0) ? err0_o : err1_o;
`endif
      end
    end
    req0_i = 1'b0; req1_i = 1'b0;
    if (we && !mis) model_store(addr, wdata, size);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({ack0_o, ack1_o, mem_we_o, busy_o} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {ack0_o, ack1_o, mem_we_o, busy_o});
    end
    n_tests++;
    if (mem_addr_o !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr_o); end
    n_tests++;
    if (mem_wdata_o !== 32'd0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata_o); end
    n_tests++;
    if ({rdata0_o, rdata1_o} !== 64'd0) begin
      n_fail++; $display("FAIL reset_rdata: got %h %h expected 0 0", rdata0_o, rdata1_o);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy_o); end
  endtask

  // Both ports request continuously: alternating word stores, period 3 cycles.
  task automatic test_round_robin();
    int order[$];
    int cyc[$];
    int c;
    req0_i = 1'b1; we0_i = 1'b1; addr0_i = 32'h40; wdata0_i = 32'hA5A5_0001; size0_i = 2'd2; uns0_i = 1'b0;
    req1_i = 1'b1; we1_i = 1'b1; addr1_i = 32'h44; wdata1_i = 32'h5A5A_0002; size1_i = 2'd2; uns1_i = 1'b0;
    c = 1;
    while (order.size() < 4 && c < 40) begin
      @(posedge clk); #1; c++;
      n_tests++;
      if (ack0_o && ack1_o) begin n_fail++; $display("FAIL rr_both_acks: both acks high at cycle %0d", c); end
      if (ack0_o) begin order.push_back(0); cyc.push_back(c); end
      if (ack1_o) begin order.push_back(1); cyc.push_back(c); end
    end
    req0_i = 1'b0; req1_i = 1'b0;
    @(posedge clk); #1;
    ref_mem[16] = 32'hA5A5_0001;
    ref_mem[17] = 32'h5A5A_0002;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (k >= order.size()) begin
        n_fail++; $display("FAIL rr_grant%0d: got no ack expected port %0d at cycle %0d", k, k % 2, 3 * (k + 1));
      end else if (order[k] !== k % 2 || cyc[k] !== 3 * (k + 1)) begin
        n_fail++; $display("FAIL rr_grant%0d: got port %0d cycle %0d expected port %0d cycle %0d",
                           k, order[k], cyc[k], k % 2, 3 * (k + 1));
      end
    end
  endtask

  task automatic test_preload();
    int lat, el, wc; logic [ADDR_W-1:0] wa; logic [31:0] rd, er, r; logic e, ee, oa;
    for (int i = 0; i < 64; i++) begin
      r = $urandom;
      run_txn(i % 2, 1'b1, 32'(i * 4), r, 2'd2, 1'b0, lat, el, wc, wa, rd, er, e, ee, oa);
      n_tests++;
      if (lat !== 3 || wc !== 1 || wa !== ADDR_W'(i)) begin
        n_fail++; $display("FAIL preload%0d: got lat %0d we %0d addr %0d expected 3 1 %0d", i, lat, wc, wa, i);
      end
    end
  endtask

  task automatic test_word_store_load();
    int lat, el, wc; logic [ADDR_W-1:0] wa; logic [31:0] rd, er; logic e, ee, oa;
    run_txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0, lat, el, wc, wa, rd, er, e, ee, oa);
    n_tests++;
    if (lat !== 3 || wc !== 1 || wa !== ADDR_W'(4)) begin
      n_fail++; $display("FAIL word_store: got lat %0d we %0d addr %0d expected 3 1 4", lat, wc, wa);
    end
    run_txn(0, 1'b0, 32'h10, 32'd0, 2'd2, 1'b0, lat, el, wc, wa, rd, er, e, ee, oa);
    n_tests++;
    if (lat !== 4 || wc !== 0 || rd !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL word_load: got lat %0d we %0d data %h expected 4 0 deadbeef", lat, wc, rd);
    end
  endtask

  task automatic test_byte_merge();
    int lat, el, wc; logic [ADDR_W-1:0] wa; logic [31:0] rd, er; logic e, ee, oa;
    run_txn(0, 1'b1, 32'h20, 32'h1122_3344, 2'd2, 1'b0, lat, el, wc, wa, rd, er, e, ee, oa);
    run_txn(0, 1'b1, 32'h22, 32'h0000_00AA, 2'd0, 1'b0, lat, el, wc, wa, rd, er, e, ee, oa);
    n_tests++;
    if (lat !== 5 || wc !== 1 || wa !== ADDR_W'(8)) begin
      n_fail++; $display("FAIL byte_store: got lat %0d we %0d addr %0d expected 5 1 8", lat, wc, wa);
    end
    run_txn(1, 1'b0, 32'h20, 32'd0, 2'd2, 1'b0, lat, el, wc, wa, rd, er, e, ee, oa);
    n_tests++;
    if (rd !== 32'h11AA_3344) begin n_fail++; $display("FAIL byte_merge_load: got %h expected 11aa3344", rd); end
  endtask

  task automatic test_extend();
    int lat, el, wc; logic [ADDR_W-1:0] wa; logic [31:0] rd, er; logic e, ee, oa;
    run_txn(1, 1'b1, 32'h30, 32'h0000_80F0, 2'd2, 1'b0, lat, el, wc, wa, rd, er, e, ee, oa);
    run_txn(0, 1'b0, 32'h30, 32'd0, 2'd1, 1'b0, lat, el, wc, wa, rd, er, e, ee, oa);
    n_tests++;
    if (rd !== 32'hFFFF_80F0) begin n_fail++; $display("FAIL half_signed: got %h expected ffff80f0", rd); end
    run_txn(1, 1'b0, 32'h30, 32'd0, 2'd0, 1'b1, lat, el, wc, wa, rd, er, e, ee, oa);
    n_tests++;
    if (rd !== 32'h0000_00F0) begin n_fail++; $display("FAIL byte_unsigned: got %h expected 000000f0", rd); end
    run_txn(0, 1'b0, 32'h31, 32'd0, 2'd0, 1'b0, lat, el, wc, wa, rd, er, e, ee, oa);
    n_tests++;
    if (rd !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL byte_signed: got %h expected ffffff80", rd); end
  endtask

  task automatic test_misalign();
    int lat, el, wc; logic [ADDR_W-1:0] wa; logic [31:0] rd, er; logic e, ee, oa;
`ifdef DMEM_MISALIGN_CHK_EN
    run_txn(0, 1'b0, 32'h06, 32'd0, 2'd2, 1'b0, lat, el, wc, wa, rd, er, e, ee, oa);
    n_tests++;
    if (lat !== 2 || e !== 1'b1 || wc !== 0 || rd !== 32'hFFFF_FF80) begin
      n_fail++; $display("FAIL misalign_word_load: got lat %0d err %b we %0d data %h expected 2 1 0 ffffff80",
                         lat, e, wc, rd);
    end
    run_txn(1, 1'b1, 32'h31, 32'h0000_1234, 2'd1, 1'b0, lat, el, wc, wa, rd, er, e, ee, oa);
    n_tests++;
    if (lat !== 2 || e !== 1'b1 || wc !== 0) begin
      n_fail++; $display("FAIL misalign_half_store: got lat %0d err %b we %0d expected 2 1 0", lat, e, wc);
    end
`else
    run_txn(0, 1'b0, 32'h31, 32'd0, 2'd1, 1'b0, lat, el, wc, wa, rd, er, e, ee, oa);
    n_tests++;
    if (lat !== 4 || rd !== 32'hFFFF_80F0) begin
      n_fail++; $display("FAIL half_ignore_a0: got lat %0d data %h expected 4 ffff80f0", lat, rd);
    end
    run_txn(1, 1'b0, 32'h0001_0033, 32'd0, 2'd2, 1'b0, lat, el, wc, wa, rd, er, e, ee, oa);
    n_tests++;
    if (lat !== 4 || rd !== 32'h0000_80F0) begin
      n_fail++; $display("FAIL word_ignore_low_wrap: got lat %0d data %h expected 4 000080f0", lat, rd);
    end
`endif
  endtask

  task automatic test_random();
    int lat, el, wc, p; logic [ADDR_W-1:0] wa; logic [31:0] rd, er, r, addr, wd; logic e, ee, oa, we;
    logic [1:0] size;
    for (int i = 0; i < 200; i++) begin
      r = $urandom; wd = $urandom;
      addr = ($urandom & 32'hFFFF_0000) | (r & 32'h0000_00FF);
      we = r[8]; size = r[10:9]; p = int'(r[11]);
      run_txn(p, we, addr, wd, size, r[12], lat, el, wc, wa, rd, er, e, ee, oa);
      n_tests++;
      if (lat !== el || wc !== ((we && !ee) ? 1 : 0) || e !== ee || oa !== 1'b0) begin
        n_fail++; $display("FAIL rand%0d_ctrl: got lat %0d we %0d err %b other %b expected %0d %0d %b 0",
                           i, lat, wc, e, oa, el, (we && !ee) ? 1 : 0, ee);
      end
      n_tests++;
      if (we && !ee && wa !== ADDR_W'(word_idx(addr))) begin
        n_fail++; $display("FAIL rand%0d_waddr: got %0d expected %0d", i, wa, word_idx(addr));
      end
      n_tests++;
      if (!we && rd !== er) begin n_fail++; $display("FAIL rand%0d_rdata: got %h expected %h", i, rd, er); end
      n_tests++;
      if (rdata0_o !== exp_rd[0] || rdata1_o !== exp_rd[1]) begin
        n_fail++; $display("FAIL rand%0d_hold: got %h %h expected %h %h", i, rdata0_o, rdata1_o, exp_rd[0], exp_rd[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, el, wc; logic [ADDR_W-1:0] wa; logic [31:0] rd, er; logic e, ee, oa, seen;
    req1_i = 1'b1; we1_i = 1'b1; addr1_i = 32'h21; wdata1_i = 32'h0000_0055; size1_i = 2'd0; uns1_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk); #1;
      if (mem_we_o) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL rstmid_merge_wr: got no write expected mem_we_o"); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({mem_we_o, busy_o, ack0_o, ack1_o} !== 4'b0000) begin
      n_fail++; $display("FAIL rstmid_drop: got %b expected 0000", {mem_we_o, busy_o, ack0_o, ack1_o});
    end
    req1_i = 1'b0;
    exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got busy %b expected 0", busy_o); end
    run_txn(1, 1'b1, 32'h21, 32'h0000_0055, 2'd0, 1'b0, lat, el, wc, wa, rd, er, e, ee, oa);
    n_tests++;
    if (lat !== 5 || wc !== 1) begin n_fail++; $display("FAIL rstmid_reissue: got lat %0d we %0d expected 5 1", lat, wc); end
    run_txn(0, 1'b0, 32'h20, 32'd0, 2'd2, 1'b0, lat, el, wc, wa, rd, er, e, ee, oa);
    n_tests++;
    if (rd !== er || rd[15:8] !== 8'h55) begin n_fail++; $display("FAIL rstmid_load: got %h expected %h", rd, er); end
  endtask

  initial begin
    req0_i = 1'b0; req1_i = 1'b0; we0_i = 1'b0; we1_i = 1'b0; uns0_i = 1'b0; uns1_i = 1'b0;
    addr0_i = 32'd0; addr1_i = 32'd0; wdata0_i = 32'd0; wdata1_i = 32'd0; size0_i = 2'd0; size1_i = 2'd0;
    exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
    test_reset();
    test_round_robin();
    test_preload();
    test_word_store_load();
    test_byte_merge();
    test_extend();
    test_misalign();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
